// File: rtl/mul_pkg.sv
// Shared types for the time-shared signed shift-add multiplier.
// Imported by the scheduler top.
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mul_sched_state_t;

endpackage

// File: rtl/arb_rr_nbit.sv
// Round-robin arbiter: search starts one past the last accepted grant.
// last_grant advances only when the grant is actually accepted.
module arb_rr_nbit #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic                i_accept,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_idx,
    output logic                o_any
);

    logic [ID_WIDTH-1:0] last_grant;
    logic                found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_req[(int'(last_grant) + i) % NUM_REQ]) begin
                found = 1'b1;
                o_grant[(int'(last_grant) + i) % NUM_REQ] = 1'b1;
                o_grant_idx = ID_WIDTH'((int'(last_grant) + i) % NUM_REQ);
            end
        end
    end

    assign o_any = |i_req;

    // Reset to the top slot so requester 0 wins the first contest.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
        end else if (i_accept) begin
            last_grant <= o_grant_idx;
        end
    end

endmodule

// File: rtl/mul_shift_sched.sv
// One iterative signed shift-add multiplier shared by NUM_REQ requesters.
// Round-robin grant in IDLE, DW BUSY steps, result held in DONE until taken.
module mul_shift_sched
    import mul_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_num_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_num_y,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [2*DATA_WIDTH-1:0]       o_res,
    output logic [ID_WIDTH-1:0]           o_res_id,
    output logic                          o_busy
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    mul_sched_state_t state, state_nx;

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_WIDTH-1:0]     gnt_idx;
    logic                    any_req;
    logic                    accept;
    logic                    last_step;
    logic [DATA_WIDTH-1:0]   x_sel;
    logic [DATA_WIDTH-1:0]   y_sel;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] x_sh;
    logic [2*DATA_WIDTH-1:0] pp;
    logic [DATA_WIDTH-1:0]   y_sh;
    logic [CW-1:0]           cnt;
    logic [ID_WIDTH-1:0]     id_q;

    arb_rr_nbit #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req_valid),
        .i_accept    (accept),
        .o_grant     (gnt),
        .o_grant_idx (gnt_idx),
        .o_any       (any_req)
    );

    assign accept    = (state == S_IDLE) && any_req;
    assign last_step = (cnt == LAST);
    assign x_sel     = i_req_num_x[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign y_sel     = i_req_num_y[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign pp        = y_sh[0] ? x_sh : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        o_req_ready = '0;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    o_req_ready = gnt;
                    state_nx    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_step) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (i_res_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The MSB of y carries negative weight, so the final step subtracts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc  <= '0;
            x_sh <= '0;
            y_sh <= '0;
            cnt  <= '0;
            id_q <= '0;
        end else if (accept) begin
            acc  <= '0;
            x_sh <= {{DATA_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel};
            y_sh <= y_sel;
            cnt  <= '0;
            id_q <= gnt_idx;
        end else if (state == S_BUSY) begin
            acc  <= last_step ? acc - pp : acc + pp;
            x_sh <= x_sh << 1;
            y_sh <= y_sh >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

    assign o_res_valid = (state == S_DONE);
    assign o_busy      = (state != S_IDLE);
    assign o_res       = acc;
    assign o_res_id    = id_q;

endmodule

// File: tb/tb_mul_shift_sched.sv
// Scoreboard bench for mul_shift_sched: accepts push expected products,
// a negedge monitor pops and compares every delivered result.
module tb_mul_shift_sched;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [DW-1:0]   ax [N];
    logic [DW-1:0]   ay [N];
    logic [N*DW-1:0] num_x;
    logic [N*DW-1:0] num_y;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready;
    logic [2*DW-1:0] res;
    logic [IW-1:0]   res_id;
    logic            busy;

    always #5 clk = ~clk;

    always_comb begin
        num_x = '0;
        num_y = '0;
        for (int k = 0; k < N; k++) begin
            num_x[k*DW +: DW] = ax[k];
            num_y[k*DW +: DW] = ay[k];
        end
    end

    mul_shift_sched #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_num_x (num_x),
        .i_req_num_y (num_y),
        .o_req_ready (req_ready),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res       (res),
        .o_res_id    (res_id),
        .o_busy      (busy)
    );

    typedef struct {
        int          id;
        logic [15:0] val;
    } exp_t;

    exp_t         exp_q[$];
    int           grant_log[$];
    int           total = 0;
    int           bad = 0;
    int           issued[N];
    int           received[N];
    int           last_acc_id;
    logic [N-1:0] last_rdy;

    function automatic logic [15:0] ref_mul(logic [7:0] x, logic [7:0] y);
        int a;
        int b;
        int p;
        a = int'($signed(x));
        b = int'($signed(y));
        p = a * b;
        return 16'(p);
    endfunction

    function automatic logic [7:0] rnd_op();
        case ($urandom % 8)
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            3: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic chk(string nm, longint act, longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // One clock: record handshakes at negedge, drop accepted valids after the edge.
    task automatic cyc();
        logic [N-1:0] acc_mask;
        exp_t e;
        acc_mask = '0;
        @(negedge clk);
        last_rdy = req_ready;
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                e.id  = k;
                e.val = ref_mul(ax[k], ay[k]);
                exp_q.push_back(e);
                grant_log.push_back(k);
                issued[k]++;
                last_acc_id = k;
                acc_mask[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic issue(int k, logic [7:0] x, logic [7:0] y);
        ax[k] = x;
        ay[k] = y;
        req_valid[k] = 1'b1;
        last_acc_id = -1;
        for (int i = 0; i < 40 && last_acc_id < 0; i++) cyc();
        chk("issue_accept", last_acc_id, k);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) cyc();
        chk("drain_timeout", longint'(exp_q.size() != 0 || busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            total++;
            if ((busy && req_ready != '0) || !$onehot0(req_ready) ||
                ((req_ready & ~req_valid) != '0)) begin
                bad++;
                $display("FAIL ready_rule: ready=%b valid=%b busy=%b",
                         req_ready, req_valid, busy);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_id", longint'(res_id), e.id);
                    chk("res_val", longint'(res), longint'(e.val));
                end
                received[res_id]++;
            end
        end
    end

    initial begin
        int edges;
        int n_iss;
        int guard;
        logic [15:0] hold_res;
        logic [IW-1:0] hold_id;
        int exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '0;
        res_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            ax[k] = '0;
            ay[k] = '0;
            issued[k] = 0;
            received[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res", longint'(res), 0);
        chk("rst_res_id", longint'(res_id), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_req_ready", longint'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 * 5 on requester 0: ready pulse and latency
        ax[0] = 8'd3;
        ay[0] = 8'd5;
        req_valid[0] = 1'b1;
        cyc();
        chk("single_ready", longint'(last_rdy), 4'b0001);
        edges = 1;
        for (int i = 0; i < 30 && !res_valid; i++) begin
            cyc();
            edges++;
            if (i == 0) chk("ready_pulse", longint'(last_rdy), 0);
        end
        chk("latency_edges", edges, 9);
        chk("single_res", longint'(res), 16'h000F);
        wait_drain();

        // signed corners
        issue(0, 8'h80, 8'h80);
        wait_drain();
        issue(1, 8'h80, 8'h7F);
        wait_drain();
        issue(2, 8'hFF, 8'hFF);
        wait_drain();
        issue(3, 8'h00, 8'hB3);
        wait_drain();

        // round robin from reset with all valid
        do_reset();
        grant_log.delete();
        for (int k = 0; k < N; k++) begin
            ax[k] = rnd_op();
            ay[k] = rnd_op();
        end
        req_valid = '1;
        for (int i = 0; i < 200 && grant_log.size() < 5; i++) begin
            cyc();
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) begin
                    ax[k] = rnd_op();
                    ay[k] = rnd_op();
                    req_valid[k] = 1'b1;
                end
            end
        end
        req_valid = '0;
        chk("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("rr_order", grant_log[i], exp_order[i]);
        wait_drain();

        // backpressure in DONE
        res_ready = 1'b0;
        issue(1, 8'hFB, 8'h07);
        for (int i = 0; i < 30 && !res_valid; i++) cyc();
        chk("bp_done", longint'(res_valid), 1);
        hold_res = res;
        hold_id = res_id;
        ax[2] = 8'h11;
        ay[2] = 8'hF0;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("bp_valid", longint'(res_valid), 1);
            chk("bp_res", longint'(res), longint'(hold_res));
            chk("bp_id", longint'(res_id), longint'(hold_id));
            chk("bp_no_grant", longint'(last_rdy), 0);
        end
        res_ready = 1'b1;
        last_acc_id = -1;
        for (int i = 0; i < 10 && last_acc_id < 0; i++) cyc();
        chk("bp_next_grant", last_acc_id, 2);
        req_valid = '0;
        wait_drain();

        // reset mid-BUSY
        issue(3, 8'd9, 8'hF7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(res_valid), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_res", longint'(res), 0);
        chk("mid_rst_id", longint'(res_id), 0);
        chk("mid_rst_ready", longint'(req_ready), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(2, 8'hE7, 8'd11);
        wait_drain();

        // random traffic
        for (int k = 0; k < N; k++) begin
            issued[k] = 0;
            received[k] = 0;
        end
        n_iss = 0;
        guard = 0;
        while (n_iss < 2000 && guard < 60000) begin
            cyc();
            guard++;
            res_ready = ($urandom % 10) < 7;
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom % 3 == 0) begin
                        ax[k] = rnd_op();
                        ay[k] = rnd_op();
                        req_valid[k] = 1'b1;
                    end
                end else if ($urandom % 40 == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            n_iss = issued[0] + issued[1] + issued[2] + issued[3];
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_drain();
        chk("rand_ops", longint'(n_iss >= 2000), 1);
        for (int k = 0; k < N; k++)
            chk("rand_per_id", received[k], issued[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
